// File: rtl/add_sub_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder/subtractor.
package add_sub_pkg;

    // Encoding of the op_sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest result the saturation helper can describe.
    localparam int SAT_MAX_W = 1024;

    // Width of one carry-chain segment.
    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Segments must tile the word exactly and each must hold at least one bit.
    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (width <= SAT_MAX_W) &&
               ((width % stages) == 0);
    endfunction

    // Signed clamp value: sign=0 gives the largest positive, sign=1 the most negative.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int width);
        logic [SAT_MAX_W-1:0] r;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < width - 1)
                r[i] = ~sign;
            else if (i == width - 1)
                r[i] = sign;
            else
                r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG_W-bit ripple-carry segment. Also exposes the carry into
// its top bit so the stage holding the word MSB can derive signed overflow.
module adder_segment #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             msb_carry_in
);

    logic [SEG_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout         = c[SEG_W];
    assign msb_carry_in = c[SEG_W-1];

endmodule

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell; the building block of each carry-chain segment.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub.sv
// Carry-pipelined WIDTH-bit adder/subtractor with optional signed saturation.
// Segment k of the sum is formed in pipeline stage k; unused high operand
// slices ride forward with the beat and finished low result slices are held
// until the whole word leaves the last stage together.
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG_W = seg_width(WIDTH, STAGES);
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_value(1'b0, WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_value(1'b1, WIDTH));

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // vld_pipe[0] is the incoming beat, vld_pipe[k+1] the beat leaving stage k.
    logic [STAGES:0] vld_pipe;
    logic [STAGES:1] vld_q;
    logic            adv;

    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[STAGES];
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;

    // Subtract is A + ~B + 1; cin only matters when adding.
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = (op_sub == OP_SUB) ? ~b : b;
    assign c0    = (op_sub == OP_SUB) ? 1'b1 : cin;

    // Valid chain: the whole pipeline moves together or not at all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_q <= '0;
        else if (adv)
            vld_q <= vld_pipe[STAGES-1:0];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * SEG_W;
        localparam int HI_W = WIDTH - LO;

        // Operand bits still to be added (this segment and everything above).
        logic [HI_W-1:0]       a_in;
        logic [HI_W-1:0]       b_in;
        logic                  c_in;
        logic                  sat_in;
        logic [SEG_W-1:0]      seg_sum;
        logic                  seg_cout;
        logic                  seg_msb_c;
        // Result bits finished so far, including this segment.
        logic [LO+SEG_W-1:0]   s_acc;

        if (k == 0) begin : g_first
            assign a_in   = a;
            assign b_in   = b_eff;
            assign c_in   = c0;
            assign sat_in = sat_en;
            assign s_acc  = seg_sum;
        end else begin : g_next
            assign a_in   = g_stage[k-1].g_reg.a_q;
            assign b_in   = g_stage[k-1].g_reg.b_q;
            assign c_in   = g_stage[k-1].g_reg.c_q;
            assign sat_in = g_stage[k-1].g_reg.sat_q;
            assign s_acc  = {seg_sum, g_stage[k-1].g_reg.s_q};
        end

        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a            (a_in[SEG_W-1:0]),
            .b            (b_in[SEG_W-1:0]),
            .cin          (c_in),
            .sum          (seg_sum),
            .cout         (seg_cout),
            .msb_carry_in (seg_msb_c)
        );

        if (k < STAGES - 1) begin : g_reg
            logic [HI_W-SEG_W-1:0] a_q;
            logic [HI_W-SEG_W-1:0] b_q;
            logic [LO+SEG_W-1:0]   s_q;
            logic                  c_q;
            logic                  sat_q;
            // Only the top segment's MSB carry feeds the overflow flag.
            logic                  unused_msb_c;

            assign unused_msb_c = seg_msb_c;

            // Carry each beat's own carry and skewed operands; bubbles leave the registers alone.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    c_q   <= 1'b0;
                    sat_q <= 1'b0;
                end else if (adv && vld_pipe[k]) begin
                    a_q   <= a_in[HI_W-1:SEG_W];
                    b_q   <= b_in[HI_W-1:SEG_W];
                    s_q   <= s_acc;
                    c_q   <= seg_cout;
                    sat_q <= sat_in;
                end
            end
        end else begin : g_out
            logic             ovf_raw;
            logic [WIDTH-1:0] s_final;

            // Operands share a sign and the result flipped it: carry in/out of the MSB differ.
            assign ovf_raw = seg_cout ^ seg_msb_c;
            assign s_final = (sat_in && ovf_raw) ? (a_in[HI_W-1] ? SAT_NEG : SAT_POS) : s_acc;

            // Output registers only load on a real beat so they hold through bubbles and stalls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum      <= '0;
                    cout     <= 1'b0;
                    overflow <= 1'b0;
                    zero     <= 1'b0;
                end else if (adv && vld_pipe[k]) begin
                    sum      <= s_final;
                    cout     <= seg_cout;
                    overflow <= ovf_raw;
                    zero     <= (s_final == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: a 4-stage and a 1-stage instance, an arithmetic
// reference model with per-DUT scoreboards, and directed literal vectors.
module tb_pipelined_add_sub;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic        cin, op_sub, sat_en, out_ready;
    logic        in_valid4, in_ready4, out_valid4, cout4, ovf4, zero4;
    logic        in_valid1, in_ready1, out_valid1, cout1, ovf1, zero1;
    logic [31:0] sum4, sum1;

    int tests = 0;
    int fails = 0;

    res_t q4[$];
    res_t q1[$];
    logic [31:0] res4[$];
    bit   collect4 = 0;
    bit   stall4 = 0, stall1 = 0;
    logic [34:0] hold4, hold1;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .sat_en(sat_en),
        .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4),
        .cout(cout4), .overflow(ovf4), .zero(zero4)
    );

    pipelined_add_sub #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .sat_en(sat_en),
        .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
        .cout(cout1), .overflow(ovf1), .zero(zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mc, input logic msub, input logic msat);
        res_t   m;
        longint sa, sb, r, ua, ub;
        sa = $signed(ma);
        sb = $signed(mb);
        ua = {32'b0, ma};
        ub = {32'b0, mb};
        r  = msub ? (sa - sb) : (sa + sb + longint'(mc));
        m.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        m.cout = msub ? (ua >= ub) : ((ua + ub + longint'(mc)) > 64'sd4294967295);
        if (msat && m.ovf)
            m.sum = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else
            m.sum = r[31:0];
        m.zero = (m.sum == 32'd0);
        return m;
    endfunction

    // Scoreboard / protocol checker, sampled mid-cycle.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            q4.delete();
            q1.delete();
            stall4 = 0;
            stall1 = 0;
        end else begin
            chk("in_ready4", in_ready4, !(out_valid4 && !out_ready));
            if (stall4) begin
                chk("hold_valid4", out_valid4, 1);
                chk("hold_out4", {sum4, cout4, ovf4, zero4}, hold4);
            end
            if (out_valid4 && out_ready) begin
                chk("sb_nonempty4", q4.size() != 0, 1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("sb_sum4", sum4, e.sum);
                    chk("sb_cout4", cout4, e.cout);
                    chk("sb_ovf4", ovf4, e.ovf);
                    chk("sb_zero4", zero4, e.zero);
                    if (collect4) res4.push_back(sum4);
                end
            end
            if (in_valid4 && in_ready4) q4.push_back(model(a, b, cin, op_sub, sat_en));
            stall4 = out_valid4 && !out_ready;
            hold4  = {sum4, cout4, ovf4, zero4};

            chk("in_ready1", in_ready1, !(out_valid1 && !out_ready));
            if (stall1) begin
                chk("hold_valid1", out_valid1, 1);
                chk("hold_out1", {sum1, cout1, ovf1, zero1}, hold1);
            end
            if (out_valid1 && out_ready) begin
                chk("sb_nonempty1", q1.size() != 0, 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("sb_sum1", sum1, e.sum);
                    chk("sb_cout1", cout1, e.cout);
                    chk("sb_ovf1", ovf1, e.ovf);
                    chk("sb_zero1", zero1, e.zero);
                end
            end
            if (in_valid1 && in_ready1) q1.push_back(model(a, b, cin, op_sub, sat_en));
            stall1 = out_valid1 && !out_ready;
            hold1  = {sum1, cout1, ovf1, zero1};
        end
    end

    // One beat into the chosen DUT; checks latency and literal results.
    task automatic send(input bit one, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts, input logic tsat,
                        input logic [31:0] esum, input logic ecout, input logic eovf,
                        input logic ezero, input string nm);
        int n;
        a = ta; b = tb; cin = tc; op_sub = ts; sat_en = tsat;
        if (one) in_valid1 = 1'b1; else in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        n = 1;
        while (!(one ? out_valid1 : out_valid4) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, one ? 1 : 4);
        chk({nm, "_sum"},  one ? sum1  : sum4,  esum);
        chk({nm, "_cout"}, one ? cout1 : cout4, ecout);
        chk({nm, "_ovf"},  one ? ovf1  : ovf4,  eovf);
        chk({nm, "_zero"}, one ? zero1 : zero4, ezero);
    endtask

    initial begin
        int idx;
        bit seen;
        rst = 1'b1;
        a = '0; b = '0; cin = 0; op_sub = 0; sat_en = 0; out_ready = 1;
        in_valid4 = 0; in_valid1 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid4", out_valid4, 0);
        chk("rst_in_ready4", in_ready4, 1);
        chk("rst_sum4", sum4, 0);
        chk("rst_flags4", {cout4, ovf4, zero4}, 0);
        chk("rst_out_valid1", out_valid1, 0);
        chk("rst_in_ready1", in_ready1, 1);
        chk("rst_sum1", sum1, 0);

        // Directed literal vectors (4-stage).
        send(0, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 32'h8000_0000, 0, 1, 0, "ovf_add");
        send(0, 32'h7FFF_FFFF, 32'h1, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 0, "sat_pos");
        send(0, 32'd5, 32'd7, 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, "sub_neg");
        send(0, 32'h8000_0000, 32'h1, 0, 1, 1, 32'h8000_0000, 1, 1, 0, "sat_neg");
        send(0, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 32'h0, 1, 0, 1, "carry_full");
        send(0, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 32'h8000_0000, 1, 1, 0, "sat_nonzero");
        send(0, 32'd10, 32'd3, 1, 1, 0, 32'd7, 1, 0, 0, "sub_cin_ignored");
        send(0, 32'h1234, 32'h1234, 0, 1, 0, 32'h0, 1, 0, 1, "sub_equal");
        // Single-stage instance.
        send(1, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 32'h0, 1, 0, 1, "s1_carry_full");
        send(1, 32'h7FFF_FFFF, 32'h1, 0, 0, 1, 32'h7FFF_FFFF, 0, 1, 0, "s1_sat_pos");
        @(posedge clk); #1;

        // Back-to-back stream with a downstream stall over cycles 5-9.
        collect4 = 1;
        op_sub = 0; sat_en = 0; cin = 0;
        idx = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 9);
            if (idx <= 8) begin
                a = idx; b = 100 * idx; in_valid4 = 1'b1;
            end else begin
                in_valid4 = 1'b0;
            end
            @(negedge clk);
            if (in_valid4 && in_ready4) idx++;
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        out_ready = 1'b1;
        collect4 = 0;
        chk("stream_count", res4.size(), 8);
        for (int i = 0; i < 8 && i < res4.size(); i++)
            chk($sformatf("stream_res%0d", i), res4[i], 101 * (i + 1));

        // Random traffic with random backpressure into both instances.
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom;
            if (i % 5 == 0) b = a;
            cin = 1'($urandom_range(1)); op_sub = 1'($urandom_range(1));
            sat_en = 1'($urandom_range(1)); out_ready = ($urandom_range(3) != 0);
            in_valid4 = 1'b1; in_valid1 = 1'b1;
            @(posedge clk); #1;
        end
        in_valid4 = 0; in_valid1 = 0; out_ready = 1;
        repeat (8) @(posedge clk);
        #1;

        // Asynchronous reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            a = 32'h10 + i; b = 32'h1; op_sub = 0; sat_en = 0; cin = 0;
            in_valid4 = 1'b1; in_valid1 = 1'b1;
            @(posedge clk); #1;
        end
        in_valid4 = 0; in_valid1 = 0;
        @(posedge clk); #1;
        chk("pre_reset_valid4", out_valid4, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid4", out_valid4, 0);
        chk("async_rst_valid1", out_valid1, 0);
        chk("async_rst_sum4", sum4, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid4 || out_valid1) seen = 1;
        end
        chk("post_reset_quiet", seen, 0);

        chk("drain4_empty", q4.size(), 0);
        chk("drain1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised successor to the team's single-cycle 32-bit ripple-carry adder.
- Generalised to any WIDTH, split into STAGES carry-pipelined segments.
- Adds a subtract mode, optional signed saturation and a zero flag.
- Uses valid/ready handshaking on both sides; sits in the ALU datapath between operand fetch and the writeback arbiter.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, pipeline depth; carry-chain segments of SEG_W = WIDTH/STAGES bits. WIDTH % STAGES must be 0; 1 <= STAGES <= WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used in add mode only.
- op_sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
- sat_en  in  1  1 = clamp signed overflow.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB (in sub mode, 1 = no borrow).
- overflow  out  1  signed overflow of the unsaturated result.
- zero  out  1  final sum (after saturation) == 0.

Behaviour:
- Reset (async, active-high):
  - all stage valid bits clear; out_valid=0; sum=0; cout=0; overflow=0; zero=0.
  - in_ready=1 on the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight beat; none reappear after reset.
- Advance condition: adv = !(out_valid && !out_ready). in_ready = adv.
  - The pipeline moves as a whole when adv=1 and holds all registers otherwise.
  - Accept happens when in_valid && in_ready.
- Latency and throughput:
  - An accepted beat appears on out_valid exactly STAGES cycles later, with no stalls.
  - Throughput is 1 beat/cycle.
  - With out_valid=1 and out_ready=1, a new input is accepted in the same cycle.
- Operand conditioning (at accept):
  - b_eff = op_sub ? ~b : b.
  - c0 = op_sub ? 1 : cin.
- Segment k (0..STAGES-1):
  - computes bits [k*SEG_W +: SEG_W] in pipeline stage k, using the carry registered from segment k-1 (c0 for k=0).
  - Higher operand slices are skewed forward; lower result slices are deskewed through registers so all bits of a beat leave together.
  - A bubble (invalid) stage must not corrupt a neighbouring beat's carry.
- Final-stage flags (after the full sum S is formed):
  - cout = carry out of bit WIDTH-1.
  - overflow = (a[W-1] == b_eff[W-1]) && (S[W-1] != a[W-1]).
  - sum = S when !(sat_en && overflow).
  - Otherwise sum = a[W-1] ? {1'b1, {W-1{0}}} : {1'b0, {W-1{1}}}.
  - overflow reports the unsaturated condition regardless of sat_en.
  - zero is computed on the final sum.
  - op_sub, sat_en and the sign/flag inputs travel with the beat.
- Outputs are registered and stable while out_valid && !out_ready.
  - Outputs are don't-care when out_valid=0, but sum/flags hold their last value; they do not toggle.
- STAGES=1: latency 1; behaves as a registered single-segment adder with handshake.

Decomposition:
- Package add_sub_pkg:
  - op encoding constants OP_ADD=0, OP_SUB=1.
  - function sat_value(sign, width) returning the signed max/min pattern.
  - localparam helper SEG_W derivation and a legality check (WIDTH % STAGES == 0).
- Sub-module adder_segment:
  - combinational SEG_W-bit ripple chain built from full_adder_1bit instances.
  - ports a, b, cin, sum, cout, plus msb_carry_in for the overflow calculation.
  - instantiated STAGES times via generate.
- Top level owns the skew/deskew registers, the valid chain, the handshake and the saturation logic.

Test Plan:
- Latency and signed overflow (WIDTH=32, STAGES=4): a=0x7FFFFFFF, b=1, add, sat_en=0 -> sum=0x80000000, overflow=1, cout=0, zero=0; out_valid exactly 4 cycles after accept.
- Positive saturation: same operands with sat_en=1 -> sum=0x7FFFFFFF, overflow=1.
- Subtract:
  - a=5, b=7, op_sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0.
  - a=0x80000000, b=1, op_sub=1, sat_en=1 -> sum=0x80000000, overflow=1.
- Full-width carry propagation: a=0xFFFFFFFF, b=0, cin=1, add -> sum=0, cout=1, zero=1. Carry crosses all 3 segment boundaries.
- Backpressure:
  - Stream 8 beats a=i, b=100*i back-to-back; drop out_ready for cycles 5-9.
  - Required: results 101*i in order with no loss or duplicates.
  - in_ready=0 exactly while out_valid && !out_ready; outputs stable during the stall.
- Reset and STAGES=1:
  - Assert rst asynchronously with 3 beats in flight -> out_valid=0 immediately and none emerge after release.
  - Rerun the carry-propagation case with STAGES=1 -> latency 1.
